// File: rtl/mel_log_compress.sv
// Mel energy log2 compressor: buffers IN_WIDTH-word chunks and emits one Q4.4 log2 value per handshake.
// Optional MEL_LOG_ROUND_EN adds round-half-up on the fraction with saturation at 0xFF.
module mel_log_compress #(
    parameter int IN_WIDTH  = 20,
    parameter int FRAME_LEN = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in [IN_WIDTH],
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic [5:0]  m_index,
    output logic        m_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] frame_count
);

    localparam int            PW       = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(IN_WIDTH - 1);
    localparam logic [5:0]    LAST_IDX = 6'(FRAME_LEN - 1);

    typedef enum logic {
        EMPTY,
        DRAIN
    } state_t;

    state_t        state_q;
    logic [15:0]   chunk_q [IN_WIDTH];
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [7:0]    data_q;
    logic [7:0]    data_d;
    logic          valid_q;
    logic [5:0]    index_q;
    logic [5:0]    index_d;
    logic [15:0]   frame_count_q;
    logic          s_hs;
    logic          m_hs;
    logic          last_word;
    logic [15:0]   log_src;

    // Exponent is the leading-one position; fraction is the next four bits down.
    function automatic logic [7:0] log_q44(input logic [15:0] x);
        logic [3:0] e;
        logic [3:0] f;
        logic [7:0] res;
`ifdef MEL_LOG_ROUND_EN
        logic       rnd;
        logic [8:0] sum;
`endif
        e = '0;
        f = '0;
        for (int i = 1; i < 16; i++) begin
            if (x[i]) e = 4'(i);
        end
        for (int k = 0; k < 4; k++) begin
            if (int'(e) > k) f[3-k] = x[e - 4'(k + 1)];
        end
        res = {e, f};
`ifdef MEL_LOG_ROUND_EN
        rnd = 1'b0;
        if (int'(e) > 4) rnd = x[e - 4'd5];
        sum = {1'b0, res} + 9'(rnd);
        res = sum[8] ? 8'hFF : sum[7:0];
`endif
        return res;
    endfunction

    assign s_hs      = s_valid & s_ready;
    assign m_hs      = valid_q & m_ready;
    assign last_word = (ptr_q == LAST_PTR);
    assign s_ready   = (state_q == EMPTY) | (m_hs & last_word);

    assign ptr_d   = ptr_q + PW'(1);
    assign index_d = (index_q == LAST_IDX) ? 6'd0 : index_q + 6'd1;
    assign log_src = s_hs ? in[0] : chunk_q[ptr_d];
    assign data_d  = log_q44(log_src);

    // Payload storage needs no reset; only the control state does.
    always_ff @(posedge clk) begin
        if (s_hs) chunk_q <= in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= EMPTY;
            ptr_q         <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            index_q       <= '0;
            frame_count_q <= '0;
        end else begin
            if (m_hs) begin
                index_q <= index_d;
                if (index_q == LAST_IDX) frame_count_q <= frame_count_q + 16'd1;
            end
            // A new chunk wins over the drain-complete transition in the same cycle.
            if (s_hs) begin
                ptr_q   <= '0;
                data_q  <= data_d;
                valid_q <= 1'b1;
                state_q <= DRAIN;
            end else if (m_hs) begin
                if (!last_word) begin
                    ptr_q  <= ptr_d;
                    data_q <= data_d;
                end else begin
                    valid_q <= 1'b0;
                    state_q <= EMPTY;
                end
            end
        end
    end

    assign m_valid     = valid_q;
    assign m_data      = data_q;
    assign m_index     = index_q;
    assign m_last      = (index_q == LAST_IDX);
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_mel_log_compress.sv
// Scoreboard bench for mel_log_compress: directed chunks push expectations, a negedge monitor pops and compares.
module tb_mel_log_compress;

    localparam int IN_WIDTH  = 20;
    localparam int FRAME_LEN = 40;

    typedef struct {
        logic [7:0] data;
        logic [5:0] index;
        logic       last;
        logic       chunkEnd;
    } expItem_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] inBus [IN_WIDTH];
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  m_data;
    logic [5:0]  m_index;
    logic        m_last;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] frame_count;

    expItem_t sbQueue [$];
    int       nChecks = 0;
    int       nFails = 0;
    int       expIdx = 0;
    int       expFrames = 0;
    int       popCount = 0;
    int       popStreak = 0;
    int       drainStreak = 0;
    bit       readyRandom = 1'b0;
    bit       readyConst = 1'b0;

    logic [15:0] wA [IN_WIDTH];
    logic [7:0]  eA [IN_WIDTH];
    logic [15:0] wB [IN_WIDTH];
    logic [7:0]  eB [IN_WIDTH];
    logic [15:0] tabVal [7];
    logic [7:0]  tabExp [7];

    mel_log_compress #(
        .IN_WIDTH (IN_WIDTH),
        .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (inBus),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_index    (m_index),
        .m_last     (m_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Arithmetic reference: exponent by repeated shifting, fraction by scaling.
    function automatic logic [7:0] modelLog(input int x);
        int e;
        int res;
        if (x < 2) return 8'h00;
        e = 0;
        while ((x >> (e + 1)) != 0) e++;
        res = e * 16 + (((x * 16) >> e) & 15);
`ifdef MEL_LOG_ROUND_EN
        res = res + (((x * 32) >> e) & 1);
        if (res > 255) res = 255;
`endif
        return 8'(res);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic noteFail(input string name);
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s: event did not occur as required at %0t", name, $time);
    endtask

    task automatic buildChunk(input int base, input int step,
                              output logic [15:0] w [IN_WIDTH], output logic [7:0] e [IN_WIDTH]);
        for (int i = 0; i < IN_WIDTH; i++) begin
            w[i] = 16'(base + i * step);
            e[i] = modelLog(int'(w[i]));
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic applyStimulus(input logic [15:0] w [IN_WIDTH], input logic [7:0] e [IN_WIDTH]);
        expItem_t item;
        bit accepted;
        accepted = 1'b0;
        inBus = w;
        s_valid = 1'b1;
        for (int guard = 0; guard < 2000 && !accepted; guard++) begin
            @(negedge clk);
            if (s_ready) begin
                accepted = 1'b1;
                for (int i = 0; i < IN_WIDTH; i++) begin
                    item.data     = e[i];
                    item.index    = 6'(expIdx);
                    item.last     = (expIdx == FRAME_LEN - 1);
                    item.chunkEnd = (i == IN_WIDTH - 1);
                    sbQueue.push_back(item);
                    if (item.last) expFrames++;
                    expIdx = (expIdx == FRAME_LEN - 1) ? 0 : expIdx + 1;
                end
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (!accepted) noteFail("chunk_accept_timeout");
    endtask

    task automatic waitDrain();
        bit done;
        done = 1'b0;
        for (int guard = 0; guard < 3000 && !done; guard++) begin
            @(negedge clk);
            #1;
            if (sbQueue.size() == 0) begin
                done = 1'b1;
                drainStreak = popStreak;
            end
        end
        if (!done) begin
            noteFail("drain_timeout");
            sbQueue.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : readyDriver
        forever begin
            @(posedge clk);
            #2;
            m_ready = readyRandom ? 1'($urandom_range(0, 1)) : readyConst;
        end
    end

    initial begin : monitor
        expItem_t   item;
        bit         stallPrev;
        bit         popped;
        logic [7:0] heldData;
        logic [5:0] heldIndex;
        logic       heldLast;
        stallPrev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stallPrev = 1'b0;
                popStreak = 0;
            end else begin
                if (stallPrev) begin
                    checkOutput("stall_valid", m_valid, 1);
                    checkOutput("stall_data", m_data, heldData);
                    checkOutput("stall_index", m_index, heldIndex);
                    checkOutput("stall_last", m_last, heldLast);
                end
                popped = 1'b0;
                if (m_valid) begin
                    if (sbQueue.size() == 0) begin
                        noteFail("unexpected_word");
                    end else if (m_ready) begin
                        item = sbQueue.pop_front();
                        checkOutput("m_data", m_data, item.data);
                        checkOutput("m_index", m_index, item.index);
                        checkOutput("m_last", m_last, item.last);
                        checkOutput("s_ready_on_word", s_ready, item.chunkEnd);
                        popped = 1'b1;
                        popCount++;
                    end else begin
                        checkOutput("stall_s_ready", s_ready, 0);
                    end
                end
                popStreak = popped ? popStreak + 1 : 0;
                stallPrev = m_valid && !m_ready;
                heldData  = m_data;
                heldIndex = m_index;
                heldLast  = m_last;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int p0;
        tabVal = '{16'h0000, 16'h0001, 16'h0003, 16'h0300, 16'h8000, 16'h0118, 16'hFFFF};
`ifdef MEL_LOG_ROUND_EN
        tabExp = '{8'h00, 8'h00, 8'h18, 8'h98, 8'hF0, 8'h82, 8'hFF};
`else
        tabExp = '{8'h00, 8'h00, 8'h18, 8'h98, 8'hF0, 8'h81, 8'hFF};
`endif
        for (int i = 0; i < IN_WIDTH; i++) inBus[i] = 16'h0;

        #12;
        checkOutput("rst_s_ready", s_ready, 1);
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_m_data", m_data, 0);
        checkOutput("rst_m_index", m_index, 0);
        checkOutput("rst_m_last", m_last, 0);
        checkOutput("rst_frame_count", frame_count, 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back chunks with m_ready held high.
        readyConst = 1'b1;
        buildChunk(0, 1, wA, eA);
        buildChunk(20, 1, wB, eB);
        p0 = popCount;
        applyStimulus(wA, eA);
        applyStimulus(wB, eB);
        waitDrain();
        checkOutput("b2b_words", popCount - p0, 40);
        checkOutput("b2b_streak", drainStreak, 40);
        checkOutput("b2b_frame_count", frame_count, expFrames);

        // Hand-computed log table.
        for (int i = 0; i < IN_WIDTH; i++) begin
            wA[i] = tabVal[i % 7];
            eA[i] = tabExp[i % 7];
        end
        applyStimulus(wA, eA);
        waitDrain();

        // Random backpressure.
        readyRandom = 1'b1;
        buildChunk(17, 3271, wA, eA);
        buildChunk(40000, 1237, wB, eB);
        applyStimulus(wA, eA);
        applyStimulus(wB, eB);
        waitDrain();
        checkOutput("bp_frame_count", frame_count, expFrames);

        // Reset pulse after exactly seven output words.
        readyRandom = 1'b0;
        readyConst = 1'b0;
        buildChunk(300, 50, wA, eA);
        applyStimulus(wA, eA);
        readyConst = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        readyConst = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_m_valid", m_valid, 0);
        checkOutput("midrst_s_ready", s_ready, 1);
        checkOutput("midrst_m_index", m_index, 0);
        checkOutput("midrst_frame_count", frame_count, 0);
        sbQueue.delete();
        expIdx = 0;
        expFrames = 0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        readyConst = 1'b1;
        buildChunk(5, 999, wA, eA);
        buildChunk(65535, 7, wB, eB);
        applyStimulus(wA, eA);
        applyStimulus(wB, eB);
        waitDrain();
        checkOutput("postrst_frame_count", frame_count, 1);

        // frame_count wrap.
        force dut.frame_count_q = 16'hFFFF;
        #1;
        release dut.frame_count_q;
        @(negedge clk);
        checkOutput("wrap_preload", frame_count, 16'hFFFF);
        @(posedge clk);
        #1;
        buildChunk(1, 1, wA, eA);
        buildChunk(1000, 1000, wB, eB);
        applyStimulus(wA, eA);
        applyStimulus(wB, eB);
        waitDrain();
        checkOutput("wrap_frame_count", frame_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/mel_log_compress.md
# mel_log_compress

Downstream consumer of the mel bank reshaper. Accepts chunks of `IN_WIDTH` 16-bit mel energies over a valid/ready handshake and converts each energy to an 8-bit Q4.4 log2 value. Emits the results as a serial stream, one coefficient per handshake, tagged with its index within the feature frame and a last-of-frame flag. The stream feeds the feature buffer of the classifier.

## Interface

- `IN_WIDTH`, 20, words per input chunk; must divide `FRAME_LEN`
- `FRAME_LEN`, 40, coefficients per feature frame; at most 64
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `in`  in  16 x `IN_WIDTH`  unpacked array of unsigned mel energies; `in[0]` is emitted first
- `s_valid`  in  1  chunk valid
- `s_ready`  out  1  chunk accepted when `s_valid & s_ready`
- `m_data`  out  8  Q4.4 log2 of the current coefficient
- `m_index`  out  6  coefficient position in frame, 0..`FRAME_LEN`-1
- `m_last`  out  1  high when `m_index == FRAME_LEN-1`
- `m_valid`  out  1  output word valid
- `m_ready`  in  1  downstream accepts when `m_valid & m_ready`
- `frame_count`  out  16  completed frames, wraps 0xFFFF -> 0

## Operation

- Two states:
  - EMPTY: no chunk held.
  - DRAIN: chunk held in a buffer of `IN_WIDTH` x 16 bits; `word_ptr` selects the word on the output.
- `s_ready = (state==EMPTY) | (m_valid & m_ready & word_ptr==IN_WIDTH-1)`.
  - Combinational from `m_ready`, which allows back-to-back chunks with no bubble.
- Chunk handshake:
  - Buffer <= `in`.
  - `word_ptr` <= 0.
  - Output register <= log(`in[0]`).
  - State <= DRAIN.
- Output handshake with `word_ptr < IN_WIDTH-1`:
  - `word_ptr`++.
  - Output register <= log(buffer[`word_ptr`+1]).
- Output handshake with `word_ptr == IN_WIDTH-1`:
  - If a chunk handshake occurs in the same cycle, it takes effect as above.
  - Otherwise state <= EMPTY and `m_valid` <= 0.
- `m_index` advances by 1 on every output handshake and wraps to 0 after `FRAME_LEN-1`. It is independent of chunk boundaries.
- `frame_count` increments on each output handshake with `m_last` high.
- Log conversion of a 16-bit value x:
  - x == 0 or x == 1 -> 0x00.
  - Otherwise e = index of the leading one (1..15).
  - f = the 4 bits directly below the leading one, MSB-first, zero-padded when e < 4.
  - Result = {e[3:0], f}.
  - Purely combinational. No division and no lookup tables.

## Timing

- Reset values: `s_ready`=1, `m_valid`=0, `m_data`=0, `m_index`=0, `m_last`=0, `frame_count`=0. State = EMPTY.
- Latency:
  - Chunk handshake at edge N -> `m_valid`=1 with word 0 after edge N.
  - Under continuous `m_ready`, one word is emitted per cycle; `IN_WIDTH` cycles per chunk.
- Stall: while `m_valid & !m_ready`, `m_data`, `m_index` and `m_last` hold stable and `s_ready` is 0.
- `s_valid` without `s_ready` is ignored, and `in` is not sampled.
- Reset asserted mid-frame:
  - Held chunk discarded, index returns to 0.
  - Partial frame not counted.
  - Outputs take reset values immediately, without waiting for a clock edge.
- `m_valid` never depends combinationally on `m_ready`.

## Configuration

- `MEL_LOG_ROUND_EN` defined:
  - Add the bit at position e-5 (0 if e < 5) to the 8-bit result.
  - Saturate at 0xFF.
- Not defined: the fraction is truncated and no rounding logic is instantiated.

## Test plan

- Log values, truncating build:
  - 0x0000 -> 0x00, 0x0001 -> 0x00, 0x0003 -> 0x18.
  - 0x0300 -> 0x98, 0x8000 -> 0xF0, 0x0118 -> 0x81, 0xFFFF -> 0xFF.
- Rounding build with `MEL_LOG_ROUND_EN`:
  - 0x0118 -> 0x82.
  - 0xFFFF -> 0xFF (saturated).
  - 0x0300 -> 0x98 (unchanged).
- Back-to-back chunks, `m_ready` tied 1, two chunks of 20 words 0..19 and 20..39:
  - 40 consecutive valid cycles, `m_index` 0..39, `m_last` only on index 39.
  - `frame_count` 0 -> 1.
- Random `m_ready` backpressure at 50%:
  - Outputs stable during every stall.
  - No word lost or duplicated.
  - `s_ready` low until the last word of the chunk is handshaken.
- Reset pulse after 7 output words:
  - `m_valid` 0 and `s_ready` 1 immediately.
  - Next chunk starts at `m_index` 0 with `frame_count` 0.
- `frame_count` wrap:
  - Preload state near the limit via 65536 frames or force.
  - 0xFFFF -> 0x0000 on the next `m_last` handshake.
